mem_port_arb: RTL and testbench
===============================

Name: mem_port_arb

Overview:
- Arbitrates one shared memory port between the instruction-fetch requester (IF) and the load/store requester (LS).
- Sits between the fetch unit / LSU and the single RAM/bus port.
- Holds at most one outstanding transaction.
- Registers the granted request and routes the response back only to the granted requester.
- Supports dropping a stale fetch response after a redirect.

Parameters:
- ADDR_W, 64, address width on all ports.
- DATA_W, 64, memory data width; the IF return is a 32-bit slice of it.
- RESET_LAST, 0, initial round-robin pointer (0 = IF served last); used only with MEM_ARB_RR_EN.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- i_if_valid  in  1  IF request; level, held until o_if_ready
- i_if_addr  in  ADDR_W  IF address
- i_if_kill  in  1  discard the in-flight or pending IF response (branch/interrupt redirect)
- o_if_ready  out  1  IF response valid (one-cycle pulse)
- o_if_rdata  out  32  fetched instruction
- i_ls_valid  in  1  LS request; level, held until o_ls_ready
- i_ls_wen  in  1  1 = store
- i_ls_addr  in  ADDR_W  LS address
- i_ls_wdata  in  DATA_W  store data
- i_ls_wmask  in  DATA_W/8  byte strobes
- i_ls_size  in  3  access size code
- o_ls_ready  out  1  LS response / store ack (one-cycle pulse)
- o_ls_rdata  out  DATA_W  load data
- o_mem_valid  out  1  request to memory; registered
- o_mem_addr  out  ADDR_W  registered address
- o_mem_wen  out  1  registered write enable
- o_mem_wdata  out  DATA_W  registered write data
- o_mem_wmask  out  DATA_W/8  registered byte strobes
- o_mem_size  out  3  registered size; 3'b010 for IF
- i_mem_ready  in  1  memory done; also qualifies i_mem_rdata
- i_mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset: state IDLE; all o_mem_* are 0; o_if_ready and o_ls_ready are 0; drop flag is 0; RR pointer = RESET_LAST.
- States and transitions:
  - IDLE → GNT_LS when i_ls_valid.
  - IDLE → GNT_IF when i_if_valid & ~i_ls_valid & ~i_if_kill.
  - GNT_IF / GNT_LS → WAIT_IF / WAIT_LS after one cycle.
  - WAIT_x → IDLE on i_mem_ready.
- Default priority is fixed: LS over IF.
- On grant, the request fields are latched into the o_mem_* registers.
- o_mem_valid is 1 from the GNT cycle until the i_mem_ready cycle inclusive, then 0 the next cycle.
- Latency: request seen in IDLE → o_mem_valid on the next edge. Minimum turnaround is 3 cycles with a 0-wait memory. There is one IDLE bubble between back-to-back transactions.
- Responses are combinational pass-through:
  - o_ls_ready = i_mem_ready & in WAIT_LS.
  - o_if_ready = i_mem_ready & in WAIT_IF & ~drop & ~i_if_kill.
- o_if_rdata = latched addr[2] ? i_mem_rdata[63:32] : i_mem_rdata[31:0].
- o_ls_rdata = i_mem_rdata unmodified; alignment and sign extension are the LSU's job.
- The ready of the requester that is not granted stays 0.
- Kill handling:
  - i_if_kill during GNT_IF or WAIT_IF sets the drop flag.
  - The memory transaction still completes; the arbiter never aborts a bus cycle.
  - Its response is suppressed.
  - The drop flag clears on that i_mem_ready.
  - i_if_kill in IDLE blocks an IF grant that cycle only.
- Simultaneous events:
  - i_mem_ready and a new request in the same cycle: the new request is arbitrated next cycle, in IDLE.
  - Kill in the same cycle as i_mem_ready: the response is suppressed.
- A requester deasserting valid without ready is illegal; it is covered by an assertion only.
- Reset mid-transaction: the arbiter returns to IDLE and ignores any later i_mem_ready for the lost transaction. The memory side is reset by the same rst_n.

Optional Feature:
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - On contention in IDLE, grant the requester not served last.
  - The pointer updates on each grant.
- Not defined: fixed LS priority; the pointer logic is absent.

Decomposition:
- Shared package / defines.v:
  - state encodings (IDLE, GNT_IF, GNT_LS, WAIT_IF, WAIT_LS, 3 bits);
  - IF size constant 3'b010;
  - reset PC constant.
- One natural sub-module, mem_arb_pick: combinational grant select (fixed or RR) from valids, kill and the last pointer.

Test Plan:
- IF only at 0x8000_0000 with memory ready 2 cycles after valid → one o_mem_valid window, then o_if_ready pulse. rdata 0x11112222_33334444 gives o_if_rdata 0x33334444. Repeat at 0x8000_0004 → 0x11112222.
- IF and LS both requesting in IDLE (load at 0x8000_1000) → LS granted first; o_mem_wen=0, addr 0x8000_1000. IF is granted after the LS ready plus one IDLE cycle. Under MEM_ARB_RR_EN, with last = LS, IF wins instead.
- Store with wdata 0xDEADBEEF_CAFEF00D, wmask 0x0F → o_mem_wen=1 with latched data/mask stable until i_mem_ready; o_ls_ready pulses once; o_if_ready stays 0.
- IF in WAIT_IF, i_if_kill pulsed, memory ready 3 cycles later → no o_if_ready. The next IF request is granted normally and its response is delivered.
- Kill coincident with i_mem_ready → o_if_ready stays 0; the state returns to IDLE.
- rst_n low for 1 cycle during WAIT_LS → all outputs 0 next cycle; a stray i_mem_ready afterwards produces no ready pulse.

Source files
------------

// File: rtl/mem_port_arb_pkg.sv
// rtl/mem_port_arb_pkg.sv - shared state encodings and constants for mem_port_arb
package mem_port_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GNT_IF  = 3'd1,
        ST_GNT_LS  = 3'd2,
        ST_WAIT_IF = 3'd3,
        ST_WAIT_LS = 3'd4
    } arb_state_t;

    localparam logic [2:0]  IF_SIZE  = 3'b010;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational IF/LS grant select; MEM_ARB_RR_EN adds round-robin on contention
module mem_arb_pick (
    input  logic i_if_valid,
    input  logic i_ls_valid,
    input  logic i_if_kill,
`ifdef MEM_ARB_RR_EN
    input  logic i_last_ls,
`endif
    output logic o_gnt_if,
    output logic o_gnt_ls
);

    logic w_if_req;

    // a kill in the same cycle means the fetch address is already stale
    assign w_if_req = i_if_valid & ~i_if_kill;

`ifdef MEM_ARB_RR_EN
    assign o_gnt_ls = i_ls_valid & ~(w_if_req & i_last_ls);
    assign o_gnt_if = w_if_req & ~(i_ls_valid & ~i_last_ls);
`else
    assign o_gnt_ls = i_ls_valid;
    assign o_gnt_if = w_if_req & ~i_ls_valid;
`endif

endmodule

// File: rtl/mem_port_arb.sv
// rtl/mem_port_arb.sv - single-outstanding IF/LS memory port arbiter; MEM_ARB_RR_EN selects round-robin
module mem_port_arb #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int RESET_LAST = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_if_valid,
    input  logic [ADDR_W-1:0]   i_if_addr,
    input  logic                i_if_kill,
    output logic                o_if_ready,
    output logic [31:0]         o_if_rdata,
    input  logic                i_ls_valid,
    input  logic                i_ls_wen,
    input  logic [ADDR_W-1:0]   i_ls_addr,
    input  logic [DATA_W-1:0]   i_ls_wdata,
    input  logic [DATA_W/8-1:0] i_ls_wmask,
    input  logic [2:0]          i_ls_size,
    output logic                o_ls_ready,
    output logic [DATA_W-1:0]   o_ls_rdata,
    output logic                o_mem_valid,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic                o_mem_wen,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_wmask,
    output logic [2:0]          o_mem_size,
    input  logic                i_mem_ready,
    input  logic [DATA_W-1:0]   i_mem_rdata
);

    import mem_port_arb_pkg::*;

    arb_state_t          r_state;
    logic                r_drop;
    logic                r_mem_valid;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_mem_wen;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W/8-1:0] r_mem_wmask;
    logic [2:0]          r_mem_size;
    logic                w_gnt_if;
    logic                w_gnt_ls;

`ifdef MEM_ARB_RR_EN
    logic                r_last_ls;
`else
    logic                w_unused_reset_last;
    assign w_unused_reset_last = (RESET_LAST != 0);
`endif

    mem_arb_pick u_pick (
        .i_if_valid (i_if_valid),
        .i_ls_valid (i_ls_valid),
        .i_if_kill  (i_if_kill),
`ifdef MEM_ARB_RR_EN
        .i_last_ls  (r_last_ls),
`endif
        .o_gnt_if   (w_gnt_if),
        .o_gnt_ls   (w_gnt_ls)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_drop      <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wen   <= 1'b0;
            r_mem_wdata <= '0;
            r_mem_wmask <= '0;
            r_mem_size  <= '0;
`ifdef MEM_ARB_RR_EN
            r_last_ls   <= (RESET_LAST != 0);
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_ls) begin
                        r_state     <= ST_GNT_LS;
                        r_mem_valid <= 1'b1;
                        r_mem_addr  <= i_ls_addr;
                        r_mem_wen   <= i_ls_wen;
                        r_mem_wdata <= i_ls_wdata;
                        r_mem_wmask <= i_ls_wmask;
                        r_mem_size  <= i_ls_size;
`ifdef MEM_ARB_RR_EN
                        r_last_ls   <= 1'b1;
`endif
                    end else if (w_gnt_if) begin
                        r_state     <= ST_GNT_IF;
                        r_mem_valid <= 1'b1;
                        r_mem_addr  <= i_if_addr;
                        r_mem_wen   <= 1'b0;
                        r_mem_wdata <= '0;
                        r_mem_wmask <= '0;
                        r_mem_size  <= IF_SIZE;
`ifdef MEM_ARB_RR_EN
                        r_last_ls   <= 1'b0;
`endif
                    end
                end
                ST_GNT_IF: begin
                    r_state <= ST_WAIT_IF;
                    if (i_if_kill) r_drop <= 1'b1;
                end
                ST_GNT_LS: r_state <= ST_WAIT_LS;
                // a killed fetch still runs to completion; only its response is dropped
                ST_WAIT_IF: begin
                    if (i_mem_ready) begin
                        r_state     <= ST_IDLE;
                        r_mem_valid <= 1'b0;
                        r_drop      <= 1'b0;
                    end else if (i_if_kill) begin
                        r_drop <= 1'b1;
                    end
                end
                ST_WAIT_LS: begin
                    if (i_mem_ready) begin
                        r_state     <= ST_IDLE;
                        r_mem_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_mem_valid <= 1'b0;
                    r_drop      <= 1'b0;
                end
            endcase
        end
    end

    assign o_mem_valid = r_mem_valid;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wen   = r_mem_wen;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_wmask = r_mem_wmask;
    assign o_mem_size  = r_mem_size;

    assign o_ls_ready = i_mem_ready & (r_state == ST_WAIT_LS);
    assign o_if_ready = i_mem_ready & (r_state == ST_WAIT_IF) & ~r_drop & ~i_if_kill;
    assign o_if_rdata = r_mem_addr[2] ? i_mem_rdata[63:32] : i_mem_rdata[31:0];
    assign o_ls_rdata = i_mem_rdata;

    // requesters must hold valid until served; a killed fetch may let go early
    a_ls_held: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == ST_GNT_LS || r_state == ST_WAIT_LS) |-> i_ls_valid);
    a_if_held: assert property (@(posedge clk) disable iff (!rst_n)
        ((r_state == ST_GNT_IF || r_state == ST_WAIT_IF) && !r_drop && !i_if_kill) |-> i_if_valid);

endmodule

// File: tb/tb_mem_port_arb.sv
// tb/tb_mem_port_arb.sv - randomized self-checking bench for mem_port_arb against a transaction-level model
module tb_mem_port_arb;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
`ifdef MEM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_if_valid, i_if_kill, o_if_ready;
    logic [ADDR_W-1:0] i_if_addr;
    logic [31:0]       o_if_rdata;
    logic              i_ls_valid, i_ls_wen, o_ls_ready;
    logic [ADDR_W-1:0] i_ls_addr;
    logic [DATA_W-1:0] i_ls_wdata, o_ls_rdata;
    logic [7:0]        i_ls_wmask;
    logic [2:0]        i_ls_size;
    logic              o_mem_valid, o_mem_wen, i_mem_ready;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata, i_mem_rdata;
    logic [7:0]        o_mem_wmask;
    logic [2:0]        o_mem_size;

    int vec = 0;
    int err = 0;
    bit last_ls = 1'b0;

    mem_port_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_LAST(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_if_valid(i_if_valid), .i_if_addr(i_if_addr), .i_if_kill(i_if_kill),
        .o_if_ready(o_if_ready), .o_if_rdata(o_if_rdata),
        .i_ls_valid(i_ls_valid), .i_ls_wen(i_ls_wen), .i_ls_addr(i_ls_addr),
        .i_ls_wdata(i_ls_wdata), .i_ls_wmask(i_ls_wmask), .i_ls_size(i_ls_size),
        .o_ls_ready(o_ls_ready), .o_ls_rdata(o_ls_rdata),
        .o_mem_valid(o_mem_valid), .o_mem_addr(o_mem_addr), .o_mem_wen(o_mem_wen),
        .o_mem_wdata(o_mem_wdata), .o_mem_wmask(o_mem_wmask), .o_mem_size(o_mem_size),
        .i_mem_ready(i_mem_ready), .i_mem_rdata(i_mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // one arbitration round: both requests raised together in IDLE, served in model order
    task automatic do_round(input bit want_if, input bit want_ls,
                            input logic [63:0] if_addr, input logic [63:0] ls_addr,
                            input logic [63:0] ls_wdata, input logic [7:0] ls_wmask,
                            input bit ls_wen, input logic [2:0] ls_size,
                            input int lat_if, input int lat_ls,
                            input logic [63:0] rd_if, input logic [63:0] rd_ls);
        bit first_ls;
        int n;
        first_ls = want_ls && !(RR_EN && want_if && last_ls);
        n = int'(want_if) + int'(want_ls);
        i_if_valid = want_if;  i_if_addr  = if_addr;
        i_ls_valid = want_ls;  i_ls_addr  = ls_addr;
        i_ls_wdata = ls_wdata; i_ls_wmask = ls_wmask;
        i_ls_wen   = ls_wen;   i_ls_size  = ls_size;
        for (int k = 0; k < n; k++) begin
            bit          is_ls;
            int          lat;
            logic [63:0] rd;
            logic [31:0] exp_if;
            logic [68:0] exp_hdr;
            is_ls   = (k == 0) ? first_ls : !first_ls;
            lat     = is_ls ? lat_ls : lat_if;
            rd      = is_ls ? rd_ls : rd_if;
            exp_if  = ((if_addr % 8) >= 4) ? 32'(rd >> 32) : 32'(rd % 64'h1_0000_0000);
            exp_hdr = is_ls ? {1'b1, ls_addr, ls_wen, ls_size} : {1'b1, if_addr, 1'b0, 3'b010};
            sample();
            vec++;
            if (o_mem_valid !== 1'b0) begin
                err++; $display("FAIL idle_bubble: o_mem_valid got %b expected 0", o_mem_valid);
            end
            tick();
            sample();
            vec++;
            if ({o_mem_valid, o_mem_addr, o_mem_wen, o_mem_size} !== exp_hdr) begin
                err++; $display("FAIL grant_fields: got %h expected %h",
                                {o_mem_valid, o_mem_addr, o_mem_wen, o_mem_size}, exp_hdr);
            end
            if (is_ls) begin
                vec++;
                if ({o_mem_wdata, o_mem_wmask} !== {ls_wdata, ls_wmask}) begin
                    err++; $display("FAIL grant_wdata: got %h expected %h",
                                    {o_mem_wdata, o_mem_wmask}, {ls_wdata, ls_wmask});
                end
            end
            for (int j = 1; j <= lat; j++) begin
                tick();
                if (is_ls) begin
                    i_ls_addr  = {$urandom, $urandom};
                    i_ls_wdata = {$urandom, $urandom};
                end else begin
                    i_if_addr = {$urandom, $urandom};
                end
                i_mem_ready = (j == lat);
                i_mem_rdata = (j == lat) ? rd : {$urandom, $urandom};
                sample();
                vec++;
                if ({o_mem_valid, o_mem_addr, o_mem_wen, o_mem_size} !== exp_hdr ||
                    (is_ls && {o_mem_wdata, o_mem_wmask} !== {ls_wdata, ls_wmask})) begin
                    err++; $display("FAIL hold_fields: cycle %0d got %h expected %h", j,
                                    {o_mem_valid, o_mem_addr, o_mem_wen, o_mem_size}, exp_hdr);
                end
                vec++;
                if (j != lat) begin
                    if ({o_if_ready, o_ls_ready} !== 2'b00) begin
                        err++; $display("FAIL early_ready: got %b expected 00", {o_if_ready, o_ls_ready});
                    end
                end else if (is_ls) begin
                    if ({o_ls_ready, o_if_ready, o_ls_rdata} !== {2'b10, rd}) begin
                        err++; $display("FAIL ls_response: got %h expected %h",
                                        {o_ls_ready, o_if_ready, o_ls_rdata}, {2'b10, rd});
                    end
                end else begin
                    if ({o_if_ready, o_ls_ready, o_if_rdata} !== {2'b10, exp_if}) begin
                        err++; $display("FAIL if_response: got %h expected %h",
                                        {o_if_ready, o_ls_ready, o_if_rdata}, {2'b10, exp_if});
                    end
                end
            end
            tick();
            i_mem_ready = 1'b0;
            if (is_ls) i_ls_valid = 1'b0;
            else       i_if_valid = 1'b0;
            last_ls = is_ls;
        end
        sample();
        vec++;
        if ({o_mem_valid, o_if_ready, o_ls_ready} !== 3'b000) begin
            err++; $display("FAIL round_close: got %b expected 000", {o_mem_valid, o_if_ready, o_ls_ready});
        end
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_if_valid = 0; i_if_addr = '0; i_if_kill = 0;
        i_ls_valid = 0; i_ls_wen = 0; i_ls_addr = '0; i_ls_wdata = '0; i_ls_wmask = '0; i_ls_size = '0;
        i_mem_ready = 0; i_mem_rdata = '0;
        tick();
        tick();
        sample();
        vec++;
        if ({o_mem_valid, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_wmask, o_mem_size} !== '0) begin
            err++; $display("FAIL reset_mem: got %h expected 0",
                            {o_mem_valid, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_wmask, o_mem_size});
        end
        vec++;
        if ({o_if_ready, o_ls_ready} !== 2'b00) begin
            err++; $display("FAIL reset_ready: got %b expected 00", {o_if_ready, o_ls_ready});
        end
        tick();
        rst_n = 1'b1;
        last_ls = 1'b0;
        tick();
    endtask

    task automatic test_if_fetch();
        do_round(1, 0, 64'h8000_0000, '0, '0, '0, 0, 3'b000, 2, 1, 64'h1111_2222_3333_4444, '0);
        do_round(1, 0, 64'h8000_0004, '0, '0, '0, 0, 3'b000, 2, 1, 64'h1111_2222_3333_4444, '0);
    endtask

    task automatic test_contention();
        do_round(1, 1, 64'h8000_0100, 64'h8000_1000, '0, 8'hFF, 0, 3'b011, 1, 1,
                 64'hAAAA_BBBB_CCCC_DDDD, 64'h0123_4567_89AB_CDEF);
        do_round(0, 1, '0, 64'h8000_2000, '0, 8'hFF, 0, 3'b011, 1, 1, '0, 64'h5555_6666_7777_8888);
        do_round(1, 1, 64'h8000_0204, 64'h8000_1008, '0, 8'hFF, 0, 3'b010, 2, 3,
                 64'h9999_AAAA_BBBB_CCCC, 64'hFEED_FACE_0BAD_F00D);
    endtask

    task automatic test_store();
        do_round(0, 1, '0, 64'h8000_3000, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F, 1, 3'b011, 1, 3,
                 '0, 64'h0);
    endtask

    task automatic test_kill();
        i_if_valid = 1; i_if_addr = 64'h8000_0008; i_if_kill = 1;
        sample();
        tick();
        i_if_kill = 0;
        sample();
        vec++;
        if (o_mem_valid !== 1'b0) begin
            err++; $display("FAIL kill_idle_block: o_mem_valid got %b expected 0", o_mem_valid);
        end
        tick();
        sample();
        vec++;
        if ({o_mem_valid, o_mem_addr} !== {1'b1, 64'h8000_0008}) begin
            err++; $display("FAIL kill_grant: got %h expected %h", {o_mem_valid, o_mem_addr}, {1'b1, 64'h8000_0008});
        end
        tick();
        i_if_kill = 1; i_if_valid = 0;
        sample();
        tick();
        i_if_kill = 0;
        tick();
        tick();
        i_mem_ready = 1; i_mem_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
        sample();
        vec++;
        if ({o_mem_valid, o_if_ready, o_ls_ready} !== 3'b100) begin
            err++; $display("FAIL kill_drop: got %b expected 100", {o_mem_valid, o_if_ready, o_ls_ready});
        end
        tick();
        i_mem_ready = 0;
        sample();
        vec++;
        if (o_mem_valid !== 1'b0) begin
            err++; $display("FAIL kill_complete: o_mem_valid got %b expected 0", o_mem_valid);
        end
        tick();
        do_round(1, 0, 64'h8000_0010, '0, '0, '0, 0, 3'b000, 1, 1, 64'h1234_5678_9ABC_DEF0, '0);
    endtask

    task automatic test_kill_ready();
        i_if_valid = 1; i_if_addr = 64'h8000_0020;
        tick();
        tick();
        tick();
        i_mem_ready = 1; i_mem_rdata = 64'hCAFE_CAFE_CAFE_CAFE; i_if_kill = 1;
        sample();
        vec++;
        if ({o_if_ready, o_ls_ready} !== 2'b00) begin
            err++; $display("FAIL kill_with_ready: got %b expected 00", {o_if_ready, o_ls_ready});
        end
        tick();
        i_mem_ready = 0; i_if_kill = 0; i_if_valid = 0;
        sample();
        vec++;
        if (o_mem_valid !== 1'b0) begin
            err++; $display("FAIL kill_ready_idle: o_mem_valid got %b expected 0", o_mem_valid);
        end
        tick();
        sample();
        vec++;
        if (o_mem_valid !== 1'b0) begin
            err++; $display("FAIL kill_ready_no_regrant: o_mem_valid got %b expected 0", o_mem_valid);
        end
        tick();
        last_ls = 1'b0;
    endtask

    task automatic test_reset_mid();
        i_ls_valid = 1; i_ls_wen = 0; i_ls_addr = 64'h8000_4000; i_ls_wdata = 64'h1;
        i_ls_wmask = 8'hFF; i_ls_size = 3'b011;
        tick();
        tick();
        rst_n = 0; i_ls_valid = 0;
        tick();
        rst_n = 1;
        i_mem_rdata = '0;
        last_ls = 1'b0;
        sample();
        vec++;
        if ({o_mem_valid, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_wmask, o_mem_size,
             o_if_ready, o_ls_ready} !== '0) begin
            err++; $display("FAIL reset_mid_outputs: got %h expected 0",
                            {o_mem_valid, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_wmask, o_mem_size,
                             o_if_ready, o_ls_ready});
        end
        tick();
        i_mem_ready = 1; i_mem_rdata = 64'h7777_7777_7777_7777;
        sample();
        vec++;
        if ({o_mem_valid, o_if_ready, o_ls_ready} !== 3'b000) begin
            err++; $display("FAIL stray_ready: got %b expected 000", {o_mem_valid, o_if_ready, o_ls_ready});
        end
        tick();
        i_mem_ready = 0;
        sample();
        vec++;
        if (o_mem_valid !== 1'b0) begin
            err++; $display("FAIL stray_after: o_mem_valid got %b expected 0", o_mem_valid);
        end
        tick();
    endtask

    task automatic test_random();
        for (int r = 0; r < 40; r++) begin
            int          want;
            logic [63:0] a_if, a_ls;
            want = $urandom_range(1, 3);
            a_if = {$urandom, $urandom} & ~64'h3;
            a_ls = {$urandom, $urandom};
            do_round(want[0], want[1], a_if, a_ls, {$urandom, $urandom}, 8'($urandom),
                     1'($urandom), 3'($urandom), $urandom_range(1, 4), $urandom_range(1, 4),
                     {$urandom, $urandom}, {$urandom, $urandom});
        end
    endtask

    initial begin
        test_reset();
        test_if_fetch();
        test_contention();
        test_store();
        test_kill();
        test_kill_ready();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
